// File: rtl/traffic_pkg.sv
// Shared state encoding and sizing helpers for the traffic phase controller.
`default_nettype none

package traffic_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_ALL_RED = 3'd0;
    localparam logic [STATE_W-1:0] ST_GREEN   = 3'd1;
    localparam logic [STATE_W-1:0] ST_YELLOW  = 3'd2;
    localparam logic [STATE_W-1:0] ST_WALK    = 3'd3;
    localparam logic [STATE_W-1:0] ST_FLASH   = 3'd4;

    // Bits needed to count 0 .. n_vals-1.
    function automatic int tmr_width(input int n_vals);
        return (n_vals < 2) ? 1 : $clog2(n_vals);
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sec_tick_gen.sv
// Seconds prescaler: one-cycle tick every CLK_FREQ cycles, restartable by clr.
`default_nettype none

module sec_tick_gen
    import traffic_pkg::*;
#(
    parameter int CLK_FREQ = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = tmr_width(CLK_FREQ);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_FREQ - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick = (cnt_q == CNT_LAST);
        if (clr || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/traffic_phase_cntl.sv
// Round-robin intersection controller with all-red clearance and latched pedestrian WALK.
// Optional night flashing-yellow mode: define TRAFFIC_NIGHT_FLASH_EN (adds NIGHT port, FLASH state).
`default_nettype none

module traffic_phase_cntl
    import traffic_pkg::*;
#(
    parameter int CLK_FREQ    = 100,
    parameter int N_DIR       = 2,
    parameter int GREEN_SEC   = 10,
    parameter int YELLOW_SEC  = 3,
    parameter int RED_CLR_SEC = 2,
    parameter int PED_SEC     = 8
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     PED_SW,
    input  logic [N_DIR-1:0]         CAR_DET,
    output logic [N_DIR-1:0]         RED,
    output logic [N_DIR-1:0]         YELLOW,
    output logic [N_DIR-1:0]         GREEN,
    output logic                     WORK,
    output logic                     PED_ACK,
    output logic [$clog2(N_DIR)-1:0] CUR_DIR
`ifdef TRAFFIC_NIGHT_FLASH_EN
    ,
    input  logic                     NIGHT
`endif
);

    localparam int DIR_W = $clog2(N_DIR);
    localparam int SEC_W = tmr_width(max4(GREEN_SEC, YELLOW_SEC, RED_CLR_SEC, PED_SEC));
    localparam logic [DIR_W-1:0] DIR_LAST = DIR_W'(N_DIR - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic [DIR_W-1:0]   last_q, last_d;
    logic [DIR_W-1:0]   cur_dir_q, cur_dir_d;
    logic               ped_s1_q, ped_s1_d, ped_s2_q, ped_s2_d, ped_s3_q, ped_s3_d;
    logic               ped_pending_q, ped_pending_d;
    logic               prev_walk_q, prev_walk_d;
    logic [N_DIR-1:0]   car_s1_q, car_s1_d, car_s2_q, car_s2_d;
    logic [N_DIR-1:0]   red_q, red_d, yellow_q, yellow_d, green_q, green_d;
    logic               work_q, work_d;
`ifdef TRAFFIC_NIGHT_FLASH_EN
    logic               night_s1_q, night_s1_d, night_s2_q, night_s2_d;
    logic               flash_on_q, flash_on_d;
`endif

    logic               tick;
    logic               state_chg;
    logic               expire;
    logic               ped_rise;
    logic [SEC_W-1:0]   dur_m1;
    logic [DIR_W-1:0]   next_dir;

    // First approach after 'last' with demand; direction 0 always qualifies.
    function automatic logic [DIR_W-1:0] pick_dir(input logic [DIR_W-1:0] last,
                                                  input logic [N_DIR-1:0] dem);
        logic [DIR_W-1:0] idx;
        logic             found;
        pick_dir = '0;
        found    = 1'b0;
        idx      = last;
        for (int k = 0; k < N_DIR; k++) begin
            idx = (idx == DIR_LAST) ? '0 : idx + 1'b1;
            if (!found && (dem[idx] || idx == '0)) begin
                pick_dir = idx;
                found    = 1'b1;
            end
        end
    endfunction

    sec_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_tick (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (state_chg),
        .tick  (tick)
    );

    always_comb begin
        ped_s1_d = PED_SW;
        ped_s2_d = ped_s1_q;
        ped_s3_d = ped_s2_q;
        car_s1_d = CAR_DET;
        car_s2_d = car_s1_q;
        ped_rise = ped_s2_q & ~ped_s3_q;
`ifdef TRAFFIC_NIGHT_FLASH_EN
        night_s1_d = NIGHT;
        night_s2_d = night_s1_q;
`endif

        case (state_q)
            ST_GREEN:  dur_m1 = SEC_W'(GREEN_SEC - 1);
            ST_YELLOW: dur_m1 = SEC_W'(YELLOW_SEC - 1);
            ST_WALK:   dur_m1 = SEC_W'(PED_SEC - 1);
            default:   dur_m1 = SEC_W'(RED_CLR_SEC - 1);
        endcase
        expire   = tick && (sec_q == dur_m1);
        next_dir = pick_dir(last_q, car_s2_q);

        state_d   = state_q;
        last_d    = last_q;
        cur_dir_d = cur_dir_q;
        case (state_q)
            ST_ALL_RED: begin
                if (expire) begin
`ifdef TRAFFIC_NIGHT_FLASH_EN
                    if (night_s2_q) begin
                        state_d = ST_FLASH;
                    end else
`endif
                    if (ped_pending_q && !prev_walk_q) begin
                        state_d = ST_WALK;
                    end else begin
                        state_d   = ST_GREEN;
                        last_d    = next_dir;
                        cur_dir_d = next_dir;
                    end
                end
            end
            ST_GREEN:  if (expire) state_d = ST_YELLOW;
            ST_YELLOW: if (expire) state_d = ST_ALL_RED;
            ST_WALK:   if (expire) state_d = ST_ALL_RED;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            ST_FLASH: begin
                if (tick && !night_s2_q) begin
                    state_d = ST_ALL_RED;
                    last_d  = DIR_LAST;
                end
            end
`endif
            default:   state_d = ST_ALL_RED;
        endcase

        state_chg   = (state_d != state_q);
        prev_walk_d = state_chg ? (state_q == ST_WALK) : prev_walk_q;
        if (state_chg) begin
            sec_d = '0;
        end else if (tick) begin
            sec_d = sec_q + 1'b1;
        end else begin
            sec_d = sec_q;
        end

        // A press landing on the WALK entry edge survives for the next cycle.
        ped_pending_d = ped_pending_q;
        if (state_d == ST_WALK && state_q != ST_WALK) ped_pending_d = 1'b0;
        if (ped_rise) ped_pending_d = 1'b1;
`ifdef TRAFFIC_NIGHT_FLASH_EN
        if (state_d == ST_FLASH || state_q == ST_FLASH) ped_pending_d = 1'b0;

        flash_on_d = flash_on_q;
        if (state_d == ST_FLASH && state_q != ST_FLASH) begin
            flash_on_d = 1'b1;
        end else if (state_q == ST_FLASH && tick) begin
            flash_on_d = ~flash_on_q;
        end
`endif

        red_d    = '1;
        yellow_d = '0;
        green_d  = '0;
        work_d   = 1'b0;
        case (state_d)
            ST_GREEN: begin
                red_d[cur_dir_d]   = 1'b0;
                green_d[cur_dir_d] = 1'b1;
            end
            ST_YELLOW: begin
                red_d[cur_dir_d]    = 1'b0;
                yellow_d[cur_dir_d] = 1'b1;
            end
            ST_WALK: work_d = 1'b1;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            ST_FLASH: begin
                red_d    = '0;
                yellow_d = {N_DIR{flash_on_d}};
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= ST_ALL_RED;
            sec_q         <= '0;
            last_q        <= DIR_LAST;
            cur_dir_q     <= '0;
            ped_s1_q      <= 1'b0;
            ped_s2_q      <= 1'b0;
            ped_s3_q      <= 1'b0;
            ped_pending_q <= 1'b0;
            prev_walk_q   <= 1'b0;
            car_s1_q      <= '0;
            car_s2_q      <= '0;
            red_q         <= '1;
            yellow_q      <= '0;
            green_q       <= '0;
            work_q        <= 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            night_s1_q    <= 1'b0;
            night_s2_q    <= 1'b0;
            flash_on_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            sec_q         <= sec_d;
            last_q        <= last_d;
            cur_dir_q     <= cur_dir_d;
            ped_s1_q      <= ped_s1_d;
            ped_s2_q      <= ped_s2_d;
            ped_s3_q      <= ped_s3_d;
            ped_pending_q <= ped_pending_d;
            prev_walk_q   <= prev_walk_d;
            car_s1_q      <= car_s1_d;
            car_s2_q      <= car_s2_d;
            red_q         <= red_d;
            yellow_q      <= yellow_d;
            green_q       <= green_d;
            work_q        <= work_d;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            night_s1_q    <= night_s1_d;
            night_s2_q    <= night_s2_d;
            flash_on_q    <= flash_on_d;
`endif
        end
    end

    assign RED     = red_q;
    assign YELLOW  = yellow_q;
    assign GREEN   = green_q;
    assign WORK    = work_q;
    assign PED_ACK = ped_pending_q;
    assign CUR_DIR = cur_dir_q;

endmodule

`default_nettype wire
